// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat memory burst port.
// Reads assemble beats into line_o; writes stream a latched line out beat by beat.
module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t       state;
   state_t       next_state;
   logic [1:0]   count;
   logic [1:0]   next_count;
   logic [255:0] line_buf;
   logic         accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      next_count = count;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            next_count = 2'd0;
            if (write_i) begin
               next_state = WR;
               accept     = 1'b1;
            end else if (read_i) begin
               next_state = RD;
               accept     = 1'b1;
            end
         end
         RD, WR: begin
            if (resp_i) begin
               next_count = count + 2'd1;
               if (count == 2'd3) begin
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
         address_o <= 32'd0;
         burst_o   <= 64'd0;
         line_o    <= 256'd0;
         line_buf  <= 256'd0;
      end else begin
         count   <= next_count;
         read_o  <= (next_state == RD);
         write_o <= (next_state == WR);
         resp_o  <= (next_state == DONE);
         if (accept) begin
            address_o <= {address_i[31:5], 5'd0};
            if (write_i) begin
               line_buf <= line_i;
               burst_o  <= line_i[63:0];
            end
         end
         if ((state == RD) && resp_i) begin
            line_o[{count, 6'd0} +: 64] <= burst_i;
         end
         // Present the beat the memory will take next, so burst_o always tracks the live count.
         if (state == WR) begin
            burst_o <= line_buf[{next_count, 6'd0} +: 64];
         end
      end
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: reads, gapped writes,
// request priority, mid-burst reset and spurious memory strobes.
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int tests_run;
   int tests_failed;

   logic [255:0] last_line;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back read; checks per-beat handshake, completion pulse and assembled line.
   task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                                input logic [63:0] b2, input logic [63:0] b3);
      logic [63:0] beats [4];
      beats[0] = b0;
      beats[1] = b1;
      beats[2] = b2;
      beats[3] = b3;
      read_i    = 1'b1;
      address_i = addr;
      tick();
      for (int k = 0; k < 4; k++) begin
         checkOutput("rd_read_o", {255'd0, read_o}, 256'd1);
         checkOutput("rd_no_resp", {255'd0, resp_o}, 256'd0);
         checkOutput("rd_address_o", {224'd0, address_o}, {224'd0, addr & 32'hFFFF_FFE0});
         resp_i  = 1'b1;
         burst_i = beats[k];
         tick();
      end
      resp_i  = 1'b0;
      burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      checkOutput("rd_resp_o", {255'd0, resp_o}, 256'd1);
      checkOutput("rd_read_o_low", {255'd0, read_o}, 256'd0);
      checkOutput("rd_address_done", {224'd0, address_o}, {224'd0, addr & 32'hFFFF_FFE0});
      checkOutput("rd_line_o", line_o, {b3, b2, b1, b0});
      read_i = 1'b0;
      tick();
      checkOutput("rd_resp_pulse", {255'd0, resp_o}, 256'd0);
      checkOutput("rd_line_hold", line_o, {b3, b2, b1, b0});
   endtask

   initial begin
      logic [63:0] wr_exp [7];
      logic        wr_resp [7];
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      line_i    = 256'd0;
      address_i = 32'd0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      burst_i   = 64'd0;
      resp_i    = 1'b0;
      tick();
      tick();
      checkOutput("rst_resp_o", {255'd0, resp_o}, 256'd0);
      checkOutput("rst_read_o", {255'd0, read_o}, 256'd0);
      checkOutput("rst_write_o", {255'd0, write_o}, 256'd0);
      checkOutput("rst_address_o", {224'd0, address_o}, 256'd0);
      checkOutput("rst_burst_o", {192'd0, burst_o}, 256'd0);
      checkOutput("rst_line_o", line_o, 256'd0);
      rst = 1'b0;

      // Memory strobes while idle must not advance anything.
      resp_i  = 1'b1;
      burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("idle_read_o", {255'd0, read_o}, 256'd0);
         checkOutput("idle_resp_o", {255'd0, resp_o}, 256'd0);
         checkOutput("idle_line_o", line_o, 256'd0);
      end
      resp_i = 1'b0;

      applyStimulus(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
      last_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

      // Gapped write; request dropped mid-burst must not stop it.
      wr_resp[0] = 1'b0; wr_resp[1] = 1'b0; wr_resp[2] = 1'b1; wr_resp[3] = 1'b1;
      wr_resp[4] = 1'b1; wr_resp[5] = 1'b0; wr_resp[6] = 1'b1;
      wr_exp[0] = {16{4'hA}}; wr_exp[1] = {16{4'hA}}; wr_exp[2] = {16{4'hA}};
      wr_exp[3] = {16{4'hB}}; wr_exp[4] = {16{4'hC}}; wr_exp[5] = {16{4'hD}};
      wr_exp[6] = {16{4'hD}};
      line_i    = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      address_i = 32'h8000_007F;
      write_i   = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         checkOutput("wr_write_o", {255'd0, write_o}, 256'd1);
         checkOutput("wr_read_o", {255'd0, read_o}, 256'd0);
         checkOutput("wr_burst_o", {192'd0, burst_o}, {192'd0, wr_exp[i]});
         checkOutput("wr_no_resp", {255'd0, resp_o}, 256'd0);
         if (i == 2) begin
            write_i = 1'b0;
         end
         resp_i = wr_resp[i];
         tick();
      end
      resp_i = 1'b1;
      checkOutput("wr_resp_o", {255'd0, resp_o}, 256'd1);
      checkOutput("wr_write_low", {255'd0, write_o}, 256'd0);
      checkOutput("wr_address_o", {224'd0, address_o}, 256'h8000_0060);
      checkOutput("wr_line_o_kept", line_o, last_line);
      tick();
      resp_i = 1'b0;
      checkOutput("wr_resp_pulse", {255'd0, resp_o}, 256'd0);
      checkOutput("wr_idle_write_o", {255'd0, write_o}, 256'd0);

      // Both requests high: write wins.
      line_i  = {4{64'h0123_4567_89AB_CDEF}};
      read_i  = 1'b1;
      write_i = 1'b1;
      tick();
      checkOutput("both_write_o", {255'd0, write_o}, 256'd1);
      checkOutput("both_read_o", {255'd0, read_o}, 256'd0);
      resp_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      resp_i = 1'b0;
      checkOutput("both_resp_o", {255'd0, resp_o}, 256'd1);
      checkOutput("both_line_o_kept", line_o, last_line);
      read_i  = 1'b0;
      write_i = 1'b0;
      tick();

      // Reset after two read beats aborts the burst silently.
      read_i    = 1'b1;
      address_i = 32'h0000_4444;
      tick();
      resp_i  = 1'b1;
      burst_i = 64'h5555_5555_5555_5555;
      tick();
      tick();
      resp_i = 1'b0;
      rst    = 1'b1;
      tick();
      checkOutput("abort_read_o", {255'd0, read_o}, 256'd0);
      checkOutput("abort_line_o", line_o, 256'd0);
      checkOutput("abort_resp_o", {255'd0, resp_o}, 256'd0);
      rst = 1'b0;
      applyStimulus(32'h0000_4444, 64'h6, 64'h7, 64'h8, 64'h9);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
